dm_tx_encoder: RTL

Differential Manchester transmitter: accepts parallel data words over a valid/ready handshake and serializes them MSB-first onto a single line `txd`. Frames start with an optional preamble of '1' bits. Bit timing comes from the shared half-bit strobe `tx_ce2x`, the same strobe domain the line receiver uses. `txd` feeds the pad/line driver. Its output is decodable by the team's differential Manchester decoder: a transition at every bit boundary, plus a mid-bit transition for a '1'.

---
 rtl/dm_tx_encoder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dm_tx_encoder.sv
// Differential Manchester line transmitter: valid/ready word input, MSB-first serial txd output.
// Optional preamble of '1' bits is compiled in with `define DM_TX_PREAMBLE_EN.
module dm_tx_encoder #(
   parameter int unsigned DATA_W        = 8,
   parameter int unsigned PREAMBLE_BITS = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tx_ce2x,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              txd,
   output logic              tx_busy,
   output logic              tx_phase
);

   localparam int unsigned BIT_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

   if (PREAMBLE_BITS < 1 || PREAMBLE_BITS > 255) begin : g_bad_preamble
      $error("PREAMBLE_BITS must be in 1..255");
   end

`ifdef DM_TX_PREAMBLE_EN
   localparam int unsigned PRE_CNT_W = 8;
   localparam logic [1:0]  ST_PRE    = 2'd1;

   logic [PRE_CNT_W-1:0] pre_cnt, pre_cnt_d;
`endif

   logic [1:0]           state, state_d;
   logic [DATA_W-1:0]    hold, hold_d;
   logic [DATA_W-1:0]    shreg, shreg_d;
   logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_d;
   logic                 hold_full, hold_full_d;
   logic                 txd_d, phase_d;
   logic                 load;

   // The ready flop is the inverted holding-register flag.
   assign hold_full = ~tx_ready;

   // State register and all registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         hold     <= '0;
         shreg    <= '0;
         bit_cnt  <= '0;
         tx_ready <= 1'b1;
         txd      <= 1'b0;
         tx_busy  <= 1'b0;
         tx_phase <= 1'b0;
`ifdef DM_TX_PREAMBLE_EN
         pre_cnt  <= '0;
`endif
      end else begin
         state    <= state_d;
         hold     <= hold_d;
         shreg    <= shreg_d;
         bit_cnt  <= bit_cnt_d;
         tx_ready <= ~hold_full_d;
         txd      <= txd_d;
         tx_busy  <= (state_d != ST_IDLE);
         tx_phase <= phase_d;
`ifdef DM_TX_PREAMBLE_EN
         pre_cnt  <= pre_cnt_d;
`endif
      end
   end

   // tx_phase records which half of the bit the last step executed; 1 means the next step is a boundary.
   always_comb begin
      state_d     = state;
      hold_d      = hold;
      hold_full_d = hold_full;
      shreg_d     = shreg;
      bit_cnt_d   = bit_cnt;
      txd_d       = txd;
      phase_d     = tx_phase;
      load        = 1'b0;
`ifdef DM_TX_PREAMBLE_EN
      pre_cnt_d   = pre_cnt;
`endif

      if (tx_ce2x) begin
         case (state)
            ST_IDLE: begin
               if (hold_full) begin
`ifdef DM_TX_PREAMBLE_EN
                  state_d   = ST_PRE;
                  pre_cnt_d = PRE_CNT_W'(PREAMBLE_BITS - 1);
                  txd_d     = ~txd;
                  phase_d   = 1'b0;
`else
                  load      = 1'b1;
`endif
               end
            end
`ifdef DM_TX_PREAMBLE_EN
            ST_PRE: begin
               if (!tx_phase) begin
                  txd_d   = ~txd;
                  phase_d = 1'b1;
               end else if (pre_cnt != '0) begin
                  pre_cnt_d = pre_cnt - PRE_CNT_W'(1);
                  txd_d     = ~txd;
                  phase_d   = 1'b0;
               end else begin
                  load = 1'b1;
               end
            end
`endif
            ST_DATA: begin
               if (!tx_phase) begin
                  txd_d   = txd ^ shreg[DATA_W-1];
                  phase_d = 1'b1;
               end else if (bit_cnt != '0) begin
                  shreg_d   = shreg << 1;
                  bit_cnt_d = bit_cnt - BIT_CNT_W'(1);
                  txd_d     = ~txd;
                  phase_d   = 1'b0;
               end else if (hold_full) begin
                  load = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  phase_d = 1'b0;
               end
            end
            default: begin
               state_d = ST_IDLE;
               phase_d = 1'b0;
            end
         endcase

         // Word load doubles as phase 0 of the new word's MSB.
         if (load) begin
            state_d     = ST_DATA;
            shreg_d     = hold;
            hold_full_d = 1'b0;
            bit_cnt_d   = LAST_BIT;
            txd_d       = ~txd;
            phase_d     = 1'b0;
         end
      end

      if (tx_valid && !hold_full) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end
   end

endmodule
